// File: rtl/bitadder_4fa.sv
// bitadder_4fa: registered 4-bit ripple-carry adder exposing every stage carry
//   in : clk, rst (sync, active-high), in_valid, a[3:0], b[3:0], cin
//   out: s_311[3:0], cout_311, w1, w2, w3 (stage carries), ovf (signed), out_valid

module bitadder_4fa_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module bitadder_4fa (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s_311,
    output logic       cout_311,
    output logic       w1,
    output logic       w2,
    output logic       w3,
    output logic       ovf,
    output logic       out_valid
);
    logic [4:0] w_c;
    logic [3:0] w_s;
    logic [3:0] r_s;
    logic [3:1] r_w;
    logic       r_cout;
    logic       r_ovf;
    logic       r_valid;

    assign w_c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            bitadder_4fa_fa u_fa (
                .i_a(a[i]),
                .i_b(b[i]),
                .i_c(w_c[i]),
                .o_s(w_s[i]),
                .o_c(w_c[i+1])
            );
        end
    endgenerate

    // Inputs are only sampled under in_valid, so junk on a/b/cin never reaches the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_w     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_s;
                r_w    <= w_c[3:1];
                r_cout <= w_c[4];
                r_ovf  <= w_c[3] ^ w_c[4];
            end
        end
    end

    assign s_311     = r_s;
    assign cout_311  = r_cout;
    assign w1        = r_w[1];
    assign w2        = r_w[2];
    assign w3        = r_w[3];
    assign ovf       = r_ovf;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_bitadder_4fa.sv
// tb_bitadder_4fa: table-driven, exhaustive and random checks of bitadder_4fa
module tb_bitadder_4fa;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic [3:0] s_311;
    logic       cout_311, w1, w2, w3, ovf, out_valid;

    int n_checks = 0;
    int n_fail = 0;

    bitadder_4fa dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s_311(s_311), .cout_311(cout_311), .w1(w1), .w2(w2), .w3(w3),
        .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic [2:0] w;
        logic       ovf;
    } vec_t;

    vec_t tbl [8];

    // Reference computed from arithmetic: carry into bit k is the overflow of the k-bit low-part sum.
    task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mc,
                         output logic [3:0] es, output logic ec, output logic [2:0] ew,
                         output logic eo);
        int sum, sa, sb, r;
        sum = int'(ma) + int'(mb) + int'(mc);
        es = sum[3:0];
        ec = (sum >= 16);
        for (int k = 1; k <= 3; k++) begin
            int lo;
            lo = (int'(ma) % (1 << k)) + (int'(mb) % (1 << k)) + int'(mc);
            ew[k-1] = ((lo >> k) & 1) == 1;
        end
        sa = (ma >= 8) ? int'(ma) - 16 : int'(ma);
        sb = (mb >= 8) ? int'(mb) - 16 : int'(mb);
        r  = sa + sb + int'(mc);
        eo = (r > 7) || (r < -8);
    endtask

    task automatic check(input string name, input logic [3:0] es, input logic ec,
                         input logic [2:0] ew, input logic eo, input logic ev);
        n_checks++;
        if ({s_311, cout_311, w3, w2, w1, ovf, out_valid} !== {es, ec, ew, eo, ev}) begin
            n_fail++;
            $display("FAIL %s: got s=%h cout=%b w3w2w1=%b%b%b ovf=%b out_valid=%b, expected s=%h cout=%b w3w2w1=%b ovf=%b out_valid=%b",
                     name, s_311, cout_311, w3, w2, w1, ovf, out_valid, es, ec, ew, eo, ev);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] ta,
                        input logic [3:0] tb, input logic tc);
        @(negedge clk);
        rst = r; in_valid = v; a = ta; b = tb; cin = tc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] es;
        logic ec, eo;
        logic [2:0] ew;

        //            a     b     cin  s     cout w(3..1) ovf
        tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
        tbl[1] = '{4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 3'b000, 1'b0};
        tbl[2] = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 3'b000, 1'b0};
        tbl[3] = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 3'b001, 1'b0};
        tbl[4] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 3'b111, 1'b0};
        tbl[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 3'b111, 1'b1};
        tbl[6] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 3'b000, 1'b1};
        tbl[7] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 3'b111, 1'b0};

        // Reset held with valid operands present
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b1, 4'h5, 4'h3, 1'b1);
            check("reset", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        end

        // Directed table, back-to-back
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            check($sformatf("table[%0d]", i), tbl[i].s, tbl[i].cout, tbl[i].w, tbl[i].ovf, 1'b1);
        end

        // Hold: last result was F+F+1; changing inputs without in_valid must not disturb it
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
            check("hold", 4'hF, 1'b1, 3'b111, 1'b0, 1'b0);
        end

        // Reset wins over in_valid in the same cycle
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        check("rst_priority", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);

        // First result after reset release appears one cycle after in_valid
        step(1'b0, 1'b1, 4'h7, 4'h1, 1'b0);
        check("post_reset", 4'h8, 1'b0, 3'b111, 1'b1, 1'b1);

        // Mid-stream reset then idle: nothing pending survives
        step(1'b1, 1'b0, 4'h3, 4'h3, 1'b0);
        check("mid_reset", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
        check("idle_after_reset", 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(1'b0, 1'b1, v[8:5], v[4:1], v[0]);
            model(v[8:5], v[4:1], v[0], es, ec, ew, eo);
            check($sformatf("exh a=%h b=%h cin=%b", v[8:5], v[4:1], v[0]), es, ec, ew, eo, 1'b1);
        end

        // Random mix of valid and idle cycles against the model
        begin
            logic [3:0] la, lb;
            logic lc, lv;
            logic [3:0] hs;
            logic hc, ho;
            logic [2:0] hw;
            model(4'hF, 4'hF, 1'b1, hs, hc, hw, ho);
            for (int i = 0; i < 300; i++) begin
                la = 4'($urandom); lb = 4'($urandom); lc = 1'($urandom);
                lv = ($urandom_range(0, 3) != 0);
                step(1'b0, lv, la, lb, lc);
                if (lv) model(la, lb, lc, hs, hc, hw, ho);
                check($sformatf("rand[%0d]", i), hs, hc, hw, ho, lv);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bitadder_4fa.md
Name: bitadder_4fa

Overview:
- 4-bit ripple-carry adder built from four 1-bit full-adder stages.
- Computes a + b + cin and exposes the sum, the carry-out and the three internal ripple carries (w1, w2, w3).
- Results are registered on one clock with a synchronous active-high reset, so the block drops directly into the synchronous datapath.
- Used as the basic arithmetic leaf for the adders/subtractors group.

Parameters:
- None. Width is fixed at 4 bits because the internal carries are exposed as individual ports.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- a  input  4  operand A, unsigned (two's-complement view used only for ovf)
- b  input  4  operand B
- cin  input  1  carry into bit 0
- s_311  output  4  registered sum bits [3:0]
- cout_311  output  1  registered carry out of bit 3
- w1  output  1  registered carry from stage 0 into stage 1
- w2  output  1  registered carry from stage 1 into stage 2
- w3  output  1  registered carry from stage 2 into stage 3
- ovf  output  1  registered signed overflow, equal to w3 XOR cout_311
- out_valid  output  1  registered outputs hold a fresh result

Behaviour:
- Full-adder stage i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
- Carry chain: c[0] = cin, c[1] = w1, c[2] = w2, c[3] = w3, c[4] = cout_311.
- Implement the chain as four full-adder instances, not as a single "+" operator, so that w1..w3 are the true stage carries.
- Arithmetic identity: {cout_311, s_311} == a + b + cin (5-bit result). Range 0..31; no saturation; wrap is carried in cout_311.
- Register update, rising clk:
  - If rst=1: s_311=0, cout_311=0, w1=w2=w3=0, ovf=0, out_valid=0.
  - Else if in_valid=1: all result registers load the combinational values of the current a, b, cin; out_valid=1.
  - Else: result registers hold their previous values; out_valid=0.
- Latency: exactly 1 cycle from in_valid sample to out_valid. Throughput: one operation per cycle, and back-to-back in_valid is allowed.
- Reset has priority over in_valid in the same cycle. Asserting reset mid-stream clears any pending result, and out_valid is 0 the cycle after.
- No combinational path from inputs to outputs.
- X/Z inputs while in_valid=0 must not disturb the held outputs.
- Boundaries:
  - a=b=4'hF, cin=1 gives s_311=4'hF, cout_311=1.
  - a=b=0, cin=0 gives all outputs 0 with out_valid=1.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=4'h5 -> all outputs 0, out_valid=0. After rst falls, first valid result appears 1 cycle after in_valid.
- Small operands, cin=0, back-to-back each with in_valid=1:
  - a=0, b=0 -> s_311=0000, cout=0, w1..w3=0
  - a=0, b=1 -> s_311=0001
  - a=1, b=0 -> s_311=0001
  - a=1, b=1 -> s_311=0010, w1=1, w2=w3=0, cout=0
- Full ripple: a=4'hF, b=4'h0, cin=1 -> s_311=0000, w1=w2=w3=1, cout_311=1, ovf=0.
- Signed overflow: a=4'h7, b=4'h1, cin=0 -> s_311=1000, w3=1, cout_311=0, ovf=1. Also a=4'h8, b=4'h8 -> s_311=0000, cout=1, w3=0, ovf=1.
- Hold and priority:
  - in_valid=0 with changing a/b -> outputs unchanged, out_valid=0.
  - rst=1 and in_valid=1 in the same cycle -> outputs cleared.
- Exhaustive: all 512 combinations of a, b, cin, back-to-back -> every result matches a+b+cin one cycle later, and w1..w3 match the reference stage carries.
